// File: rtl/store_queue_fwd_if.sv
// Bundle of signals between the store queue and its neighbours: dispatch, execute, LQ search, ROB commit/recovery and D-cache drain.
// The slave modport is the store queue itself. The master modport is the surrounding pipeline.
interface store_queue_fwd_if #(
   parameter int IDX_W  = 4,
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              disp_en_a;
   logic              disp_en_b;
   logic              disp_ok_a;
   logic              disp_ok_b;
   logic [IDX_W-1:0]  disp_idx_a;
   logic [IDX_W-1:0]  disp_idx_b;
   logic              exe_en_a;
   logic              exe_en_b;
   logic [IDX_W-1:0]  exe_idx_a;
   logic [IDX_W-1:0]  exe_idx_b;
   logic [ADDR_W-1:0] exe_addr_a;
   logic [ADDR_W-1:0] exe_addr_b;
   logic [DATA_W-1:0] exe_data_a;
   logic [DATA_W-1:0] exe_data_b;
   logic              ld_search_en;
   logic [ADDR_W-1:0] ld_addr;
   logic [IDX_W:0]    ld_sq_tail;
   logic              ld_hit;
   logic [DATA_W-1:0] ld_data;
   logic              ld_stall;
   logic              commit_en;
   logic              br_recover;
   logic [IDX_W:0]    br_tail;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ack;
   logic [IDX_W:0]    sq_tail;
   logic [IDX_W:0]    sq_count;
   logic              sq_full;
   logic              sq_almost_full;

   modport slave (
      input  disp_en_a, disp_en_b, exe_en_a, exe_en_b, exe_idx_a, exe_idx_b,
             exe_addr_a, exe_addr_b, exe_data_a, exe_data_b, ld_search_en, ld_addr,
             ld_sq_tail, commit_en, br_recover, br_tail, mem_ack,
      output disp_ok_a, disp_ok_b, disp_idx_a, disp_idx_b, ld_hit, ld_data, ld_stall,
             mem_req, mem_addr, mem_data, sq_tail, sq_count, sq_full, sq_almost_full
   );

   modport master (
      output disp_en_a, disp_en_b, exe_en_a, exe_en_b, exe_idx_a, exe_idx_b,
             exe_addr_a, exe_addr_b, exe_data_a, exe_data_b, ld_search_en, ld_addr,
             ld_sq_tail, commit_en, br_recover, br_tail, mem_ack,
      input  disp_ok_a, disp_ok_b, disp_idx_a, disp_idx_b, ld_hit, ld_data, ld_stall,
             mem_req, mem_addr, mem_data, sq_tail, sq_count, sq_full, sq_almost_full
   );
endinterface

// File: rtl/store_queue_fwd.sv
// Store queue with age-ordered store-to-load forwarding, a commit/drain split and partial squash on branch recovery.
// Each pointer is IDX_W+1 bits wide. The extra MSB is a wrap bit, so full and empty can be told apart.
module store_queue_fwd #(
   parameter int DEPTH  = 16,
   parameter int IDX_W  = 4,
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input logic              clock,
   input logic              reset,
   store_queue_fwd_if.slave bus
);
   localparam int PW = IDX_W + 1;
   localparam logic [PW-1:0] ONE_P = PW'(1);

   typedef enum logic {DR_IDLE = 1'b0, DR_REQ = 1'b1} drain_t;

   logic [PW-1:0]     head_r, cmt_r, tail_r;
   logic [DEPTH-1:0]  addr_valid_r;
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   drain_t            drain_r;
   logic              mem_req_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_data_r;

   logic [PW-1:0]     count_s, cmt_span_s, cmt_next_s, tail_next_s, alloc_b_s, srch_len_s;
   logic              ok_a_s, ok_b_s, commit_s, in_rng_a_s, in_rng_b_s, clamp_s;
   logic              stall_s, hit_s;
   logic [DATA_W-1:0] hit_data_s;

   // Dispatch grant, commit qualification and the next tail, including the recovery clamp.
   always_comb begin
      count_s = tail_r - head_r;
      ok_a_s  = 1'b0;
      ok_b_s  = 1'b0;
      if (!bus.br_recover) begin
         ok_a_s = bus.disp_en_a && (count_s <= PW'(DEPTH - 1));
         if (bus.disp_en_a) begin
            ok_b_s = bus.disp_en_b && (count_s <= PW'(DEPTH - 2));
         end else begin
            ok_b_s = bus.disp_en_b && (count_s <= PW'(DEPTH - 1));
         end
      end else begin
         ok_a_s = 1'b0;
         ok_b_s = 1'b0;
      end
      alloc_b_s  = ok_a_s ? (tail_r + ONE_P) : tail_r;
      cmt_span_s = tail_r - cmt_r;
      in_rng_a_s = {1'b0, bus.exe_idx_a - cmt_r[IDX_W-1:0]} < cmt_span_s;
      in_rng_b_s = {1'b0, bus.exe_idx_b - cmt_r[IDX_W-1:0]} < cmt_span_s;
      commit_s   = bus.commit_en && (cmt_r != tail_r) && addr_valid_r[cmt_r[IDX_W-1:0]];
      cmt_next_s = cmt_r + {{IDX_W{1'b0}}, commit_s};
      // Distances measured from head make the "below cmt" test immune to pointer wrap.
      clamp_s    = (bus.br_tail - head_r) < (cmt_next_s - head_r);
      if (bus.br_recover) begin
         tail_next_s = clamp_s ? cmt_next_s : bus.br_tail;
      end else begin
         tail_next_s = tail_r + {{IDX_W{1'b0}}, ok_a_s} + {{IDX_W{1'b0}}, ok_b_s};
      end
   end

   // Load search over [head, ld_sq_tail); walking oldest to youngest lets the youngest match win.
   always_comb begin
      stall_s    = 1'b0;
      hit_s      = 1'b0;
      hit_data_s = {DATA_W{1'b0}};
      srch_len_s = bus.ld_sq_tail - head_r;
      if (srch_len_s > PW'(DEPTH)) begin
         srch_len_s = {PW{1'b0}};
      end else begin
         srch_len_s = bus.ld_sq_tail - head_r;
      end
      for (int k = 0; k < DEPTH; k++) begin : scan
         logic [IDX_W-1:0] ent;
         ent = head_r[IDX_W-1:0] + IDX_W'(k);
         if (PW'(k) < srch_len_s) begin
            if (!addr_valid_r[ent]) begin
               stall_s = 1'b1;
            end else if (addr_mem[ent] == bus.ld_addr) begin
               hit_s      = 1'b1;
               hit_data_s = data_mem[ent];
            end else begin
               hit_s = hit_s;
            end
         end else begin
            hit_s = hit_s;
         end
      end
   end

   // Commit and tail pointers plus per-entry address-valid flags.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cmt_r        <= {PW{1'b0}};
         tail_r       <= {PW{1'b0}};
         addr_valid_r <= {DEPTH{1'b0}};
      end else begin
         cmt_r  <= cmt_next_s;
         tail_r <= tail_next_s;
         if (ok_a_s) addr_valid_r[tail_r[IDX_W-1:0]] <= 1'b0;
         if (ok_b_s) addr_valid_r[alloc_b_s[IDX_W-1:0]] <= 1'b0;
         if (bus.exe_en_a && in_rng_a_s) addr_valid_r[bus.exe_idx_a] <= 1'b1;
         if (bus.exe_en_b && in_rng_b_s) addr_valid_r[bus.exe_idx_b] <= 1'b1;
      end
   end

   // Entry payload storage. It is not reset, because addr_valid gates every use of it.
   always_ff @(posedge clock) begin
      if (bus.exe_en_a && in_rng_a_s) begin
         addr_mem[bus.exe_idx_a] <= bus.exe_addr_a;
         data_mem[bus.exe_idx_a] <= bus.exe_data_a;
      end
      if (bus.exe_en_b && in_rng_b_s) begin
         addr_mem[bus.exe_idx_b] <= bus.exe_addr_b;
         data_mem[bus.exe_idx_b] <= bus.exe_data_b;
      end
   end

   // Drain FSM: presents the head entry to memory and retires it on ack.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         drain_r    <= DR_IDLE;
         head_r     <= {PW{1'b0}};
         mem_req_r  <= 1'b0;
         mem_addr_r <= {ADDR_W{1'b0}};
         mem_data_r <= {DATA_W{1'b0}};
      end else begin
         case (drain_r)
            DR_IDLE: begin
               if (head_r != cmt_r) begin
                  drain_r    <= DR_REQ;
                  mem_req_r  <= 1'b1;
                  mem_addr_r <= addr_mem[head_r[IDX_W-1:0]];
                  mem_data_r <= data_mem[head_r[IDX_W-1:0]];
               end else begin
                  mem_req_r <= 1'b0;
               end
            end
            DR_REQ: begin
               if (bus.mem_ack) begin
                  drain_r   <= DR_IDLE;
                  mem_req_r <= 1'b0;
                  head_r    <= head_r + ONE_P;
               end else begin
                  mem_req_r <= 1'b1;
               end
            end
            default: begin
               drain_r   <= DR_IDLE;
               mem_req_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.disp_ok_a      = ok_a_s;
   assign bus.disp_ok_b      = ok_b_s;
   assign bus.disp_idx_a     = tail_r[IDX_W-1:0];
   assign bus.disp_idx_b     = alloc_b_s[IDX_W-1:0];
   assign bus.ld_stall       = bus.ld_search_en && stall_s;
   assign bus.ld_hit         = bus.ld_search_en && !stall_s && hit_s;
   assign bus.ld_data        = (bus.ld_search_en && !stall_s && hit_s) ? hit_data_s : {DATA_W{1'b0}};
   assign bus.mem_req        = mem_req_r;
   assign bus.mem_addr       = mem_addr_r;
   assign bus.mem_data       = mem_data_r;
   assign bus.sq_tail        = tail_r;
   assign bus.sq_count       = count_s;
   assign bus.sq_full        = (count_s == PW'(DEPTH));
   assign bus.sq_almost_full = (count_s == PW'(DEPTH - 1));
endmodule
